// File: rtl/brg_pkg.sv
// Shared constants and reset-divisor arithmetic for the fractional baud rate generator.
package brg_pkg;

  localparam int unsigned SYS_CLK_DEF    = 50000000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned FRAC_W_DEF     = 4;
  localparam int unsigned OS_W           = $clog2(OVERSAMPLE_DEF);

  // Integer part of clk cycles per oversample tick.
  function automatic int unsigned brg_def_int(input longint unsigned sys_clk,
                                              input longint unsigned baud,
                                              input longint unsigned oversample);
    return 32'(sys_clk / (baud * oversample));
  endfunction

  // Rounded fractional part in 1/2^frac_w units, saturated so it never spills into the integer.
  function automatic int unsigned brg_def_frac(input longint unsigned sys_clk,
                                               input longint unsigned baud,
                                               input longint unsigned oversample,
                                               input int unsigned     frac_w);
    longint unsigned d;
    longint unsigned rem;
    longint unsigned q;
    longint unsigned lim;
    d   = baud * oversample;
    rem = sys_clk % d;
    q   = ((rem << frac_w) * 64'(2) + d) / (64'(2) * d);
    lim = (64'(1) << frac_w) - 64'(1);
    if (q > lim) q = lim;
    return 32'(q);
  endfunction

endpackage

// File: rtl/brg_frac_if.sv
// Register-file side of the baud generator: divisor write port and active-divisor readback.
interface brg_frac_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
);
  logic                    div_we;
  logic [DIV_W-1:0]        div_int;
  logic [FRAC_W-1:0]       div_frac;
  logic [DIV_W+FRAC_W-1:0] cur_div;

  modport master (output div_we, div_int, div_frac, input cur_div);
  modport slave  (input div_we, div_int, div_frac, output cur_div);
endinterface

// File: rtl/brg_frac_div.sv
// Period down-counter with optional fractional accumulator; emits the registered rx tick.
// Accumulator and carry exist only when BRG_FRAC_EN is defined.
module brg_frac_div #(
  parameter int unsigned      DIV_W   = 16,
  parameter int unsigned      FRAC_W  = 4,
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic [DIV_W-1:0]  ld_int,
  input  logic [FRAC_W-1:0] ld_frac,
  output logic              reload_c,
  output logic              rx_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] base;
  logic             carry;

  // A zero divisor behaves as one.
  assign base     = (ld_int == '0) ? '0 : ld_int - DIV_W'(1);
  assign reload_c = enable && !resync && (cnt == '0);

`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, ld_frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (reset || resync) acc <= '0;
    else if (reload_c)   acc <= sum[FRAC_W-1:0];
  end
`else
  logic unused_ld_frac;
  assign unused_ld_frac = ^ld_frac;
  assign carry          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= RST_CNT;
      rx_tick <= 1'b0;
    end else begin
      rx_tick <= reload_c;
      if (resync)        cnt <= base;
      else if (reload_c) cnt <= base + DIV_W'(carry);
      else if (enable)   cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/brg_frac.sv
// Runtime-programmable UART baud generator: oversample and bit clock-enable ticks.
// Define BRG_FRAC_EN to build the fractional divisor; otherwise div_frac is ignored.
module brg_frac import brg_pkg::*; #(
  parameter int unsigned SYS_CLK    = SYS_CLK_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       resync,
  brg_frac_if.slave  bus,
  output logic       rx_tick,
  output logic       tx_tick
);

  localparam int unsigned      OS_BITS = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_INT =
    DIV_W'(brg_def_int(64'(SYS_CLK), 64'(BAUD), 64'(OVERSAMPLE)));
`ifdef BRG_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC =
    FRAC_W'(brg_def_frac(64'(SYS_CLK), 64'(BAUD), 64'(OVERSAMPLE), FRAC_W));
`else
  localparam logic [FRAC_W-1:0] DEF_FRAC = '0;
`endif

  logic [DIV_W-1:0]        act_int;
  logic [FRAC_W-1:0]       act_frac;
  logic [DIV_W-1:0]        sh_int;
  logic [FRAC_W-1:0]       sh_frac;
  logic                    pend;
  logic [OS_BITS-1:0]      os;
  logic [DIV_W+FRAC_W-1:0] cur_div_q;
  logic [FRAC_W-1:0]       wr_frac;
  logic                    reload_c;
  logic                    xfer_c;
  logic [DIV_W-1:0]        ld_int_c;
  logic [FRAC_W-1:0]       ld_frac_c;

`ifdef BRG_FRAC_EN
  assign wr_frac = bus.div_frac;
`else
  logic unused_div_frac;
  assign unused_div_frac = ^bus.div_frac;
  assign wr_frac         = '0;
`endif

  // Shadow moves to active at a reload edge, on resync, or at once while stopped.
  assign xfer_c    = pend && (resync || reload_c || !enable);
  assign ld_int_c  = xfer_c ? sh_int  : act_int;
  assign ld_frac_c = xfer_c ? sh_frac : act_frac;
  assign bus.cur_div = cur_div_q;

  brg_frac_div #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (DEF_INT - DIV_W'(1))
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .resync   (resync),
    .ld_int   (ld_int_c),
    .ld_frac  (ld_frac_c),
    .reload_c (reload_c),
    .rx_tick  (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      act_int   <= DEF_INT;
      act_frac  <= DEF_FRAC;
      sh_int    <= DEF_INT;
      sh_frac   <= DEF_FRAC;
      pend      <= 1'b0;
      os        <= '0;
      tx_tick   <= 1'b0;
      cur_div_q <= {DEF_INT, DEF_FRAC};
    end else begin
      cur_div_q <= {act_int, act_frac};
      act_int   <= ld_int_c;
      act_frac  <= ld_frac_c;
      // A write in the same cycle as a transfer re-arms the shadow.
      if (bus.div_we) begin
        sh_int  <= bus.div_int;
        sh_frac <= wr_frac;
        pend    <= 1'b1;
      end else if (xfer_c) begin
        pend    <= 1'b0;
      end
      tx_tick <= reload_c && (os == OS_BITS'(OVERSAMPLE - 1));
      if (resync)        os <= '0;
      else if (reload_c) os <= os + OS_BITS'(1);
    end
  end

endmodule

// File: doc/brg_frac.md
# brg_frac

Runtime-programmable baud rate generator for the UART. It produces single-cycle clock-enable ticks: `rx_tick` at the oversampling rate and `tx_tick` at the bit rate. A fractional accumulator lets non-integer divisors be met on average. It sits between the bus register file, which writes the divisor, and the UART transmitter and receiver, which consume the ticks as enables on `clk` and do not use them as derived clocks.

## Interface
- `SYS_CLK`, 50000000, system clock frequency in Hz.
- `BAUD`, 9600, baud rate used to compute the reset divisor.
- `OVERSAMPLE`, 16, number of `rx_tick` pulses per `tx_tick` pulse; must be a power of two, at least 2.
- `DIV_W`, 16, width of the integer divisor.
- `FRAC_W`, 4, width of the fractional divisor.
- `clk`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `enable`  in  1  run enable; when low, all counters hold.
- `resync`  in  1  one-cycle pulse that restarts the phase of all counters.
- `div_we`  in  1  write strobe for the divisor.
- `div_int`  in  DIV_W  integer divisor, in `clk` cycles per `rx_tick`.
- `div_frac`  in  FRAC_W  fractional divisor, in units of 1/2^FRAC_W.
- `cur_div`  out  DIV_W+FRAC_W  active divisor, `{int, frac}`, for readback.
- `rx_tick`  out  1  oversample tick, one `clk` cycle wide.
- `tx_tick`  out  1  bit tick, one `clk` cycle wide.

## Operation
- Reset divisor:
  - `DEF_INT = SYS_CLK / (BAUD*OVERSAMPLE)`.
  - `DEF_FRAC = round(remainder * 2^FRAC_W / (BAUD*OVERSAMPLE))`.
  - For the defaults: 325 and 8.
- Period counter `cnt` (DIV_W bits) counts down.
  - When `cnt==0` with `enable` high: `rx_tick` pulses and `cnt` reloads.
  - Reload value is `act_int-1+carry`.
  - `carry` is the overflow of `acc + act_frac` into bit FRAC_W. `acc` (FRAC_W bits) takes the wrapped sum on every `rx_tick`.
- Result: over every 2^FRAC_W `rx_tick` periods, exactly `act_frac` periods are `act_int+1` cycles long and the rest are `act_int` cycles long.
- `act_int==0` is treated as 1. With `act_int<=1` and frac 0, `rx_tick` is high every enabled cycle.
- Oversample counter `os` (log2 OVERSAMPLE bits) increments on each `rx_tick` and wraps. `tx_tick` = `rx_tick && os==OVERSAMPLE-1`, so `tx_tick` always coincides with an `rx_tick`.
- Divisor write:
  - `div_we` captures `div_int` and `div_frac` into a shadow register and sets `pend`.
  - If `enable` is high, the shadow transfers to `act_*` at the next `rx_tick` reload, so the current period completes at the old rate (glitch-free).
  - If `enable` is low, the transfer happens on the next cycle.
  - A second write before the transfer overwrites the shadow; the last write wins.
- `resync`:
  - Sets `cnt=act_int-1`, `acc=0`, `os=0`.
  - A pending shadow transfers immediately.
  - No tick is issued in the `resync` cycle.
  - `resync` has priority over `div_we` in the same cycle; the write is still captured into the shadow.
- `enable` low: `cnt`, `acc` and `os` hold, and both ticks are 0.
- `cur_div` reflects `act_*`, not the shadow.

## Timing
- Reset values:
  - `rx_tick=0`, `tx_tick=0`.
  - `cnt=DEF_INT-1`, `acc=0`, `os=0`, `pend=0`.
  - `act_*` and shadow set to `DEF_*`.
  - `cur_div={DEF_INT,DEF_FRAC}`.
- Both ticks are registered outputs.
- The first `rx_tick` is high during the `act_int`-th cycle after reset deasserts, with `enable` held high.
- A divisor write becomes visible on `cur_div` one cycle after the transferring edge.
- `reset` asserted mid-period aborts the period and any pending write. The ticks are low from the next edge.

## Configuration
- `BRG_FRAC_EN` defined: the fractional accumulator is built; `div_frac` is honoured.
- `BRG_FRAC_EN` undefined:
  - `acc` and carry are removed and `div_frac` is ignored.
  - The frac field of `cur_div` reads 0 and `DEF_FRAC` is forced to 0.
  - The period is exactly `act_int`.

## Structure
- Package `brg_pkg`:
  - Function computing `DEF_INT` and `DEF_FRAC` from `SYS_CLK`, `BAUD` and `OVERSAMPLE`.
  - Localparam `OS_W = $clog2(OVERSAMPLE)`.
- One sub-module, `brg_frac_div`: period counter plus accumulator, producing the raw `rx_tick`. The top level holds the shadow register, the `os` counter and `tx_tick`.

## Test plan
- Write `div_int=4`, `div_frac=0`, then `resync` → `rx_tick` every 4 cycles, `tx_tick` every 64 cycles, coincident with every 16th `rx_tick`.
- `div_int=4`, `div_frac=8` (FRAC_W=4) → periods alternate 4 and 5 cycles; 16 `rx_tick` periods span exactly 72 cycles. Without `BRG_FRAC_EN`, they span 64 cycles.
- Running at `div_int=10`, write `div_int=3` two cycles into a period → that period still lasts 10 cycles; the following periods last 3 cycles; `cur_div` updates one cycle after the reload edge.
- Drop `enable` for 7 cycles mid-period → no ticks during the gap; the remaining count resumes unchanged, so the period stretches by exactly 7 cycles.
- `div_int=0` and `div_int=1` with frac 0 → `rx_tick` high every enabled cycle; `tx_tick` every 16 cycles.
- Assert `reset` mid-period with a write pending → ticks are 0 from the next edge; `cur_div={325,8}`; first `rx_tick` 325 cycles after `reset` deasserts.
